// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: address-width helper,
// the default register address type and the hardwired-zero register index.
package regfile_pkg;

    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int REGNO_DEF = 32;
    localparam int AW_DEF    = addr_w(REGNO_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_mp_if.sv
// Read, write and scoreboard signals between issue/writeback (master) and the
// register file (slave).
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int REGNO  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2
);
    localparam int AW = addr_w(REGNO);

    logic [NREAD-1:0][AW-1:0]     r_addr;
    logic [NREAD-1:0][WIDTH-1:0]  r_data;
    logic [NREAD-1:0]             r_busy;
    logic [NWRITE-1:0]            w_en;
    logic [NWRITE-1:0][AW-1:0]    w_addr;
    logic [NWRITE-1:0][WIDTH-1:0] w_data;
    logic                         sb_set;
    logic [AW-1:0]                sb_addr;
    logic                         sb_flush;

    modport master (
        output r_addr, w_en, w_addr, w_data, sb_set, sb_addr, sb_flush,
        input  r_data, r_busy
    );

    modport slave (
        input  r_addr, w_en, w_addr, w_data, sb_set, sb_addr, sb_flush,
        output r_data, r_busy
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-result scoreboard: one bit per register, flush > set > writeback clear,
// and busy lookup that already sees a same-cycle writeback as complete.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int REGNO  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2,
    localparam int AW    = addr_w(REGNO)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NWRITE-1:0]         w_en,
    input  logic [NWRITE-1:0][AW-1:0] w_addr,
    input  logic                      sb_set,
    input  logic [AW-1:0]             sb_addr,
    input  logic                      sb_flush,
    input  logic [NREAD-1:0][AW-1:0]  r_addr,
    output logic [NREAD-1:0]          r_busy
);

    logic [REGNO-1:0] pending;
    logic [REGNO-1:0] pend_nxt;
    logic [REGNO-1:0] wr_any;

    always_comb begin
        wr_any = '0;
        for (int k = 0; k < NWRITE; k++) begin
            if (w_en[k]) wr_any[w_addr[k]] = 1'b1;
        end
    end

    always_comb begin
        pend_nxt = pending;
        for (int a = 1; a < REGNO; a++) begin
            if (sb_flush)
                pend_nxt[a] = 1'b0;
            else if (sb_set && sb_addr == AW'(a))
                pend_nxt[a] = 1'b1;
            else if (wr_any[a])
                pend_nxt[a] = 1'b0;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pend_nxt;
    end

    // A writeback landing this cycle makes the operand available through the data bypass.
    always_comb begin
        r_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            r_busy[i] = pending[r_addr[i]] & ~wr_any[r_addr[i]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired-zero x0, highest-port-wins writes,
// write-to-read bypass and an attached pending scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int REGNO  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2
) (
    input logic         clk,
    input logic         rst_n,
    regfile_mp_if.slave bus
);

    localparam int AW = addr_w(REGNO);

    logic [WIDTH-1:0] regs   [REGNO];
    logic [WIDTH-1:0] wr_val [REGNO];
    logic [REGNO-1:0] wr_hit;

    // Ascending port order lets the highest-indexed port overwrite lower ones.
    always_comb begin
        wr_hit = '0;
        for (int a = 0; a < REGNO; a++) wr_val[a] = '0;
        for (int k = 0; k < NWRITE; k++) begin
            if (bus.w_en[k] && bus.w_addr[k] != AW'(REG_ZERO)) begin
                wr_hit[bus.w_addr[k]] = 1'b1;
                wr_val[bus.w_addr[k]] = bus.w_data[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < REGNO; a++) regs[a] <= '0;
        end else begin
            for (int a = 1; a < REGNO; a++) begin
                if (wr_hit[a]) regs[a] <= wr_val[a];
            end
        end
    end

    // Bypass is gated by reset so reads stay zero while reset is held.
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            bus.r_data[i] = '0;
            if (rst_n && bus.r_addr[i] != AW'(REG_ZERO)) begin
                bus.r_data[i] = wr_hit[bus.r_addr[i]] ? wr_val[bus.r_addr[i]]
                                                       : regs[bus.r_addr[i]];
            end
        end
    end

    regfile_scoreboard #(
        .REGNO  (REGNO),
        .NREAD  (NREAD),
        .NWRITE (NWRITE)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .w_en     (bus.w_en),
        .w_addr   (bus.w_addr),
        .sb_set   (bus.sb_set),
        .sb_addr  (bus.sb_addr),
        .sb_flush (bus.sb_flush),
        .r_addr   (bus.r_addr),
        .r_busy   (bus.r_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset, bypass, port priority, x0, scoreboard, flush.
module tb_regfile_mp;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   fails  = 0;

    regfile_mp_if #(.WIDTH(32), .REGNO(32), .NREAD(2), .NWRITE(2)) bus ();

    regfile_mp #(.WIDTH(32), .REGNO(32), .NREAD(2), .NWRITE(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.w_en     = '0;
        bus.sb_set   = 1'b0;
        bus.sb_flush = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.r_addr   = '0;
        bus.w_en     = '0;
        bus.w_addr   = '0;
        bus.w_data   = '0;
        bus.sb_set   = 1'b0;
        bus.sb_addr  = '0;
        bus.sb_flush = 1'b0;

        // Reset held while writes and a set are driven
        bus.w_en      = 2'b11;
        bus.w_addr[0] = 5'd3;  bus.w_data[0] = 32'h1234_5678;
        bus.w_addr[1] = 5'd5;  bus.w_data[1] = 32'hCAFE_F00D;
        bus.sb_set    = 1'b1;  bus.sb_addr   = 5'd5;
        bus.r_addr[0] = 5'd3;  bus.r_addr[1] = 5'd5;
        tick(); tick();
        check("rst_rdata0", bus.r_data[0], 32'h0);
        check("rst_rdata1", bus.r_data[1], 32'h0);
        check("rst_busy0", {31'b0, bus.r_busy[0]}, 32'h0);
        check("rst_busy1", {31'b0, bus.r_busy[1]}, 32'h0);
        idle();
        #1 rst_n = 1'b1;
        tick();
        check("post_rst_x5", bus.r_data[1], 32'h0);
        check("post_rst_x5_busy", {31'b0, bus.r_busy[1]}, 32'h0);

        // Write with same-cycle bypass, then stored read
        bus.w_en = 2'b01; bus.w_addr[0] = 5'd3; bus.w_data[0] = 32'hDEAD_BEEF;
        bus.r_addr[0] = 5'd3;
        #1 check("bypass_x3", bus.r_data[0], 32'hDEAD_BEEF);
        tick(); idle();
        #1 check("stored_x3", bus.r_data[0], 32'hDEAD_BEEF);

        // Both ports write x7: port 1 wins
        bus.w_en = 2'b11;
        bus.w_addr[0] = 5'd7; bus.w_data[0] = 32'h11;
        bus.w_addr[1] = 5'd7; bus.w_data[1] = 32'h22;
        bus.r_addr[1] = 5'd7;
        #1 check("conflict_bypass_x7", bus.r_data[1], 32'h22);
        tick(); idle();
        #1 check("conflict_stored_x7", bus.r_data[1], 32'h22);

        // x0 ignores writes
        bus.w_en = 2'b01; bus.w_addr[0] = 5'd0; bus.w_data[0] = 32'h55;
        bus.r_addr[0] = 5'd0;
        #1 check("x0_bypass", bus.r_data[0], 32'h0);
        tick(); idle();
        #1 check("x0_stored", bus.r_data[0], 32'h0);

        // Scoreboard: set x9, visible next cycle; writeback clears same cycle
        bus.sb_set = 1'b1; bus.sb_addr = 5'd9; bus.r_addr[0] = 5'd9;
        #1 check("x9_busy_same_cycle", {31'b0, bus.r_busy[0]}, 32'h0);
        tick(); idle();
        #1 check("x9_busy_next", {31'b0, bus.r_busy[0]}, 32'h1);
        bus.w_en = 2'b10; bus.w_addr[1] = 5'd9; bus.w_data[1] = 32'h99;
        #1 check("x9_busy_wb_bypass", {31'b0, bus.r_busy[0]}, 32'h0);
        check("x9_data_wb_bypass", bus.r_data[0], 32'h99);
        tick(); idle();
        #1 check("x9_busy_after_wb", {31'b0, bus.r_busy[0]}, 32'h0);
        check("x9_data_after_wb", bus.r_data[0], 32'h99);

        // Set beats same-cycle writeback clear on x4
        bus.sb_set = 1'b1; bus.sb_addr = 5'd4;
        bus.w_en = 2'b01; bus.w_addr[0] = 5'd4; bus.w_data[0] = 32'h44;
        bus.r_addr[0] = 5'd4;
        #1 check("x4_busy_collide", {31'b0, bus.r_busy[0]}, 32'h0);
        tick(); idle();
        #1 check("x4_busy_next", {31'b0, bus.r_busy[0]}, 32'h1);
        check("x4_data_next", bus.r_data[0], 32'h44);

        // Flush with pending x2/x6 and a same-cycle set on x8; write x10 commits
        bus.sb_set = 1'b1; bus.sb_addr = 5'd2;
        tick();
        bus.sb_addr = 5'd6;
        tick(); idle();
        bus.r_addr[0] = 5'd2; bus.r_addr[1] = 5'd6;
        #1 check("x2_pending", {31'b0, bus.r_busy[0]}, 32'h1);
        check("x6_pending", {31'b0, bus.r_busy[1]}, 32'h1);
        bus.sb_flush = 1'b1; bus.sb_set = 1'b1; bus.sb_addr = 5'd8;
        bus.w_en = 2'b01; bus.w_addr[0] = 5'd10; bus.w_data[0] = 32'hAA;
        tick(); idle();
        #1 check("x2_flushed", {31'b0, bus.r_busy[0]}, 32'h0);
        check("x6_flushed", {31'b0, bus.r_busy[1]}, 32'h0);
        bus.r_addr[0] = 5'd8; bus.r_addr[1] = 5'd4;
        #1 check("x8_flushed", {31'b0, bus.r_busy[0]}, 32'h0);
        check("x4_flushed", {31'b0, bus.r_busy[1]}, 32'h0);
        check("x4_data_kept", bus.r_data[1], 32'h44);
        bus.r_addr[0] = 5'd10;
        #1 check("x10_flush_write", bus.r_data[0], 32'hAA);

        // Mid-operation reset clears contents and discards same-cycle write
        bus.w_en = 2'b01; bus.w_addr[0] = 5'd11; bus.w_data[0] = 32'hBB;
        bus.r_addr[0] = 5'd3; bus.r_addr[1] = 5'd11;
        #1 rst_n = 1'b0;
        #1 check("midrst_x3", bus.r_data[0], 32'h0);
        tick(); idle();
        #1 rst_n = 1'b1;
        tick();
        check("midrst_x3_after", bus.r_data[0], 32'h0);
        check("midrst_x11_discard", bus.r_data[1], 32'h0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
